// File: rtl/peb_datamux_if.sv
// Bus bundle between the TMS9900 CPU memory bus, the 16-to-8 data multiplexer
// and the 8-bit PEB expansion bus. The slave modport is the multiplexer itself;
// the master modport is the environment (CPU plus PEB cards).
interface peb_datamux_if;
    // CPU side
    logic [0:14] cpu_a;
    logic [0:15] cpu_d;
    logic [0:15] cpu_q;
    logic        cpu_q_select;
    logic        cpu_memen;
    logic        cpu_we;
    logic        cpu_ready;
    // PEB side
    logic [0:15] peb_a;
    logic [0:7]  peb_d;
    logic [0:7]  peb_q;
    logic        peb_q_select;
    logic        peb_memen;
    logic        peb_we;
    logic        peb_ready;

    modport master (
        output cpu_a, cpu_d, cpu_memen, cpu_we,
        output peb_q, peb_q_select, peb_ready,
        input  cpu_q, cpu_q_select, cpu_ready,
        input  peb_a, peb_d, peb_memen, peb_we
    );

    modport slave (
        input  cpu_a, cpu_d, cpu_memen, cpu_we,
        input  peb_q, peb_q_select, peb_ready,
        output cpu_q, cpu_q_select, cpu_ready,
        output peb_a, peb_d, peb_memen, peb_we
    );
endinterface

// File: rtl/peb_datamux.sv
// 16-to-8-bit data multiplexer between the TMS9900 CPU bus and the PEB bus.
// A CPU word access is split into two PEB byte accesses (odd byte first, then
// even byte), each followed by a wait phase of at least WAIT_STATES cycles that
// the card can stretch with peb_ready. Read bytes are assembled into cpu_q and
// cpu_ready pulses for one cycle when the word is done. All outputs are flops.
module peb_datamux #(
    parameter int unsigned WAIT_STATES = 4,
    parameter logic [7:0]  FLOAT_BYTE  = 8'hFF
) (
    input  logic          clk,
    input  logic          reset,
    peb_datamux_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ODD_ACC   = 3'd1,
        ST_ODD_WAIT  = 3'd2,
        ST_EVEN_ACC  = 3'd3,
        ST_EVEN_WAIT = 3'd4,
        ST_DONE      = 3'd5,
        ST_HOLD      = 3'd6
    } state_e;

    // Counter load value; legal WAIT_STATES range 1..15 fits in four bits.
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    state_e      state_d,        state_q;
    logic [3:0]  cnt_d,          cnt_q;
    logic [0:14] a_d,            a_q;
    logic [0:15] d_d,            d_q;
    logic        we_d,           we_q;
    logic [0:7]  lo_d,           lo_q;
    logic        lo_sel_d,       lo_sel_q;
    logic [0:15] cpu_q_d,        cpu_q_q;
    logic        cpu_q_select_d, cpu_q_select_q;
    logic        cpu_ready_d,    cpu_ready_q;
    logic [0:15] peb_a_d,        peb_a_q;
    logic [0:7]  peb_d_d,        peb_d_q;
    logic        peb_memen_d,    peb_memen_q;
    logic        peb_we_d,       peb_we_q;

    logic        wait_done_s;
    logic [3:0]  cnt_dec_s;
    logic [0:7]  rd_byte_s;

    // Wait-phase exit test, saturating counter decrement and floating-bus read byte.
    always_comb begin
        wait_done_s = (cnt_q <= 4'd1) && bus.peb_ready;
        if (cnt_q == 4'd0) begin
            cnt_dec_s = 4'd0;
        end else begin
            cnt_dec_s = cnt_q - 4'd1;
        end
        if (bus.peb_q_select) begin
            rd_byte_s = bus.peb_q;
        end else begin
            rd_byte_s = FLOAT_BYTE;
        end
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead so
    // that every bus output comes straight from a flop.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        a_d            = a_q;
        d_d            = d_q;
        we_d           = we_q;
        lo_d           = lo_q;
        lo_sel_d       = lo_sel_q;
        cpu_q_d        = cpu_q_q;
        cpu_q_select_d = cpu_q_select_q;
        cpu_ready_d    = 1'b0;
        peb_a_d        = peb_a_q;
        peb_d_d        = peb_d_q;
        peb_memen_d    = 1'b0;
        peb_we_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_memen) begin
                    // Capture the whole request so later CPU bus changes are ignored.
                    a_d         = bus.cpu_a;
                    d_d         = bus.cpu_d;
                    we_d        = bus.cpu_we;
                    peb_a_d     = {bus.cpu_a, 1'b1};
                    peb_d_d     = bus.cpu_d[8:15];
                    peb_memen_d = 1'b1;
                    peb_we_d    = bus.cpu_we;
                    state_d     = ST_ODD_ACC;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ODD_ACC: begin
                cnt_d   = WAIT_LOAD;
                state_d = ST_ODD_WAIT;
            end

            ST_ODD_WAIT: begin
                if (wait_done_s) begin
                    if (!we_q) begin
                        lo_d     = rd_byte_s;
                        lo_sel_d = bus.peb_q_select;
                    end else begin
                        lo_d     = lo_q;
                        lo_sel_d = lo_sel_q;
                    end
                    peb_a_d     = {a_q, 1'b0};
                    peb_d_d     = d_q[0:7];
                    peb_memen_d = 1'b1;
                    peb_we_d    = we_q;
                    state_d     = ST_EVEN_ACC;
                end else begin
                    cnt_d = cnt_dec_s;
                end
            end

            ST_EVEN_ACC: begin
                cnt_d   = WAIT_LOAD;
                state_d = ST_EVEN_WAIT;
            end

            ST_EVEN_WAIT: begin
                if (wait_done_s) begin
                    // The even byte goes straight into the upper half of the word.
                    if (!we_q) begin
                        cpu_q_d        = {rd_byte_s, lo_q};
                        cpu_q_select_d = bus.peb_q_select | lo_sel_q;
                    end else begin
                        cpu_q_d        = cpu_q_q;
                        cpu_q_select_d = cpu_q_select_q;
                    end
                    cpu_ready_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_dec_s;
                end
            end

            ST_DONE: begin
                state_d = ST_HOLD;
            end

            ST_HOLD: begin
                // One transaction per memen assertion: wait for the CPU to let go.
                if (!bus.cpu_memen) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 4'd0;
            a_q            <= 15'd0;
            d_q            <= 16'd0;
            we_q           <= 1'b0;
            lo_q           <= 8'd0;
            lo_sel_q       <= 1'b0;
            cpu_q_q        <= 16'd0;
            cpu_q_select_q <= 1'b0;
            cpu_ready_q    <= 1'b0;
            peb_a_q        <= 16'd0;
            peb_d_q        <= 8'd0;
            peb_memen_q    <= 1'b0;
            peb_we_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            a_q            <= a_d;
            d_q            <= d_d;
            we_q           <= we_d;
            lo_q           <= lo_d;
            lo_sel_q       <= lo_sel_d;
            cpu_q_q        <= cpu_q_d;
            cpu_q_select_q <= cpu_q_select_d;
            cpu_ready_q    <= cpu_ready_d;
            peb_a_q        <= peb_a_d;
            peb_d_q        <= peb_d_d;
            peb_memen_q    <= peb_memen_d;
            peb_we_q       <= peb_we_d;
        end
    end

    assign bus.cpu_q        = cpu_q_q;
    assign bus.cpu_q_select = cpu_q_select_q;
    assign bus.cpu_ready    = cpu_ready_q;
    assign bus.peb_a        = peb_a_q;
    assign bus.peb_d        = peb_d_q;
    assign bus.peb_memen    = peb_memen_q;
    assign bus.peb_we       = peb_we_q;

endmodule

// File: tb/tb_peb_datamux.sv
// Bench for peb_datamux: two instances (WAIT_STATES=1 and 4) share the CPU-side
// stimulus, each with its own PEB card model. Expected words and ready cycles
// are pushed to a scoreboard queue before each transaction and popped after.
module tb_peb_datamux;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [0:14] cpu_a     = 15'd0;
    logic [0:15] cpu_d     = 16'd0;
    logic        cpu_memen = 1'b0;
    logic        cpu_we    = 1'b0;
    logic        peb_ready = 1'b1;

    peb_datamux_if if1 ();
    peb_datamux_if if4 ();

    assign if1.cpu_a = cpu_a;  assign if4.cpu_a = cpu_a;
    assign if1.cpu_d = cpu_d;  assign if4.cpu_d = cpu_d;
    assign if1.cpu_memen = cpu_memen;  assign if4.cpu_memen = cpu_memen;
    assign if1.cpu_we = cpu_we;  assign if4.cpu_we = cpu_we;
    assign if1.peb_ready = peb_ready;  assign if4.peb_ready = peb_ready;

    peb_datamux #(.WAIT_STATES(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    peb_datamux #(.WAIT_STATES(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));

    // Card model: RAM at >Axxx, a byte-wide register at >6001 reading 8'h77.
    function automatic logic claim(input logic [0:15] a);
        return (a[0:3] == 4'hA) || (a == 16'h6001);
    endfunction

    logic [7:0] mem1 [0:255];
    logic [7:0] mem4 [0:255];
    logic [0:7] q1 = 8'h00;
    logic [0:7] q4 = 8'h00;
    assign if1.peb_q = q1;  assign if4.peb_q = q4;
    assign if1.peb_q_select = claim(if1.peb_a);
    assign if4.peb_q_select = claim(if4.peb_a);

    // Registered card behind the W=1 instance.
    always @(posedge clk) begin
        if (if1.peb_memen) begin
            if (if1.peb_we) begin
                if (claim(if1.peb_a) && if1.peb_a != 16'h6001) mem1[if1.peb_a[8:15]] <= if1.peb_d;
            end else if (!claim(if1.peb_a)) q1 <= 8'h5A;
            else if (if1.peb_a == 16'h6001) q1 <= 8'h77;
            else q1 <= mem1[if1.peb_a[8:15]];
        end
    end

    // Registered card behind the W=4 instance.
    always @(posedge clk) begin
        if (if4.peb_memen) begin
            if (if4.peb_we) begin
                if (claim(if4.peb_a) && if4.peb_a != 16'h6001) mem4[if4.peb_a[8:15]] <= if4.peb_d;
            end else if (!claim(if4.peb_a)) q4 <= 8'h5A;
            else if (if4.peb_a == 16'h6001) q4 <= 8'h77;
            else q4 <= mem4[if4.peb_a[8:15]];
        end
    end

    // Observed instance selection.
    bit use4 = 1'b0;
    logic [0:15] o_cpu_q, o_peb_a;
    logic [0:7]  o_peb_d;
    logic        o_cpu_q_select, o_cpu_ready, o_peb_memen, o_peb_we, x_cpu_ready;
    assign o_cpu_q        = use4 ? if4.cpu_q        : if1.cpu_q;
    assign o_cpu_q_select = use4 ? if4.cpu_q_select : if1.cpu_q_select;
    assign o_cpu_ready    = use4 ? if4.cpu_ready    : if1.cpu_ready;
    assign o_peb_a        = use4 ? if4.peb_a        : if1.peb_a;
    assign o_peb_d        = use4 ? if4.peb_d        : if1.peb_d;
    assign o_peb_memen    = use4 ? if4.peb_memen    : if1.peb_memen;
    assign o_peb_we       = use4 ? if4.peb_we       : if1.peb_we;
    assign x_cpu_ready    = use4 ? if1.cpu_ready    : if4.cpu_ready;

    typedef struct {
        logic [0:15] q;
        logic        sel;
        int          rdy;
    } exp_t;
    exp_t sb[$];

    int          pulse_cyc[$];
    logic [0:15] pulse_a[$];
    logic [0:7]  pulse_d[$];
    logic        pulse_we[$];
    logic [0:15] addr_log[$];
    bit          b2b;
    logic [43:0] snap;
    int          chk_n = 0;
    int          pass_n = 0;
    logic [0:15] model_q = 16'h0000;
    logic        model_sel = 1'b0;

    // Runs one CPU transaction. Edge 0 is the posedge where IDLE samples memen;
    // cycle c is observed at the negedge between edge c-1 and edge c.
    task automatic run_txn(input logic we, input logic [0:14] a, input logic [0:15] d,
                           input int hold, input int stall_start, input int stall_len,
                           input int reset_at, input int max_cycles,
                           output int rdy_cyc, output int n_rdy);
        bit oth_done;
        bit prev_memen;
        rdy_cyc = -1; n_rdy = 0; oth_done = 1'b0; prev_memen = 1'b0; b2b = 1'b0;
        pulse_cyc.delete(); pulse_a.delete(); pulse_d.delete(); pulse_we.delete();
        addr_log.delete();
        snap = 44'h0;
        @(negedge clk);
        cpu_we = we; cpu_a = a; cpu_d = d; cpu_memen = 1'b1; peb_ready = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= max_cycles; c++) begin
            @(negedge clk);
            peb_ready = !(c >= stall_start && c < stall_start + stall_len);
            addr_log.push_back(o_peb_a);
            if (o_peb_memen) begin
                pulse_cyc.push_back(c); pulse_a.push_back(o_peb_a);
                pulse_d.push_back(o_peb_d); pulse_we.push_back(o_peb_we);
                if (prev_memen) b2b = 1'b1;
            end
            prev_memen = o_peb_memen;
            if (o_cpu_ready) begin
                if (rdy_cyc < 0) rdy_cyc = c;
                n_rdy++;
            end
            if (x_cpu_ready) oth_done = 1'b1;
            if (c == reset_at) begin
                reset = 1'b1; cpu_memen = 1'b0;
            end else if (c == reset_at + 1) begin
                reset = 1'b0;
                snap = {o_cpu_q, o_cpu_q_select, o_cpu_ready, o_peb_a, o_peb_d, o_peb_memen, o_peb_we};
            end
            if (cpu_memen && rdy_cyc >= 0 && oth_done && c >= hold) cpu_memen = 1'b0;
        end
        cpu_memen = 1'b0;
        peb_ready = 1'b1;
    endtask

    task automatic test_reset();
        logic [43:0] v1, v4;
        cpu_memen = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        v1 = {if1.cpu_q, if1.cpu_q_select, if1.cpu_ready, if1.peb_a, if1.peb_d, if1.peb_memen, if1.peb_we};
        v4 = {if4.cpu_q, if4.cpu_q_select, if4.cpu_ready, if4.peb_a, if4.peb_d, if4.peb_memen, if4.peb_we};
        chk_n++; if (v1 !== 44'h0) $display("FAIL reset_outputs_w1: got %h want 0", v1); else pass_n++;
        chk_n++; if (v4 !== 44'h0) $display("FAIL reset_outputs_w4: got %h want 0", v4); else pass_n++;
        cpu_memen = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_n++; if (if1.peb_memen !== 1'b0) $display("FAIL reset_no_strobe: got %b want 0", if1.peb_memen); else pass_n++;
    endtask

    task automatic test_write_w1();
        int rc, nr;
        exp_t e;
        use4 = 1'b0;
        sb.push_back('{model_q, model_sel, 5});
        run_txn(1'b1, 15'h5000, 16'h1234, 0, 0, 0, -10, 20, rc, nr);
        e = sb.pop_front();
        chk_n++; if (rc !== e.rdy) $display("FAIL wr_ready_cycle: got %0d want %0d", rc, e.rdy); else pass_n++;
        chk_n++; if (nr !== 1) $display("FAIL wr_ready_count: got %0d want 1", nr); else pass_n++;
        chk_n++; if (pulse_cyc.size() !== 2) $display("FAIL wr_pulse_count: got %0d want 2", pulse_cyc.size()); else pass_n++;
        if (pulse_cyc.size() == 2) begin
            chk_n++; if (pulse_cyc[0] !== 1 || pulse_a[0] !== 16'hA001 || pulse_d[0] !== 8'h34 || pulse_we[0] !== 1'b1)
                $display("FAIL wr_odd_pulse: got c%0d a=%h d=%h we=%b want c1 a=A001 d=34 we=1", pulse_cyc[0], pulse_a[0], pulse_d[0], pulse_we[0]);
            else pass_n++;
            chk_n++; if (pulse_cyc[1] !== 3 || pulse_a[1] !== 16'hA000 || pulse_d[1] !== 8'h12 || pulse_we[1] !== 1'b1)
                $display("FAIL wr_even_pulse: got c%0d a=%h d=%h we=%b want c3 a=A000 d=12 we=1", pulse_cyc[1], pulse_a[1], pulse_d[1], pulse_we[1]);
            else pass_n++;
        end
        chk_n++; if (o_cpu_q !== e.q || o_cpu_q_select !== e.sel)
            $display("FAIL wr_q_held: got %h/%b want %h/%b", o_cpu_q, o_cpu_q_select, e.q, e.sel);
        else pass_n++;
    endtask

    task automatic test_read_back();
        int rc, nr;
        exp_t e;
        for (int w = 0; w < 2; w++) begin
            use4 = (w == 1);
            sb.push_back('{16'h1234, 1'b1, (w == 1) ? 11 : 5});
            run_txn(1'b0, 15'h5000, 16'hDEAD, 0, 0, 0, -10, 20, rc, nr);
            e = sb.pop_front();
            model_q = e.q; model_sel = e.sel;
            chk_n++; if (rc !== e.rdy) $display("FAIL rd_ready_cycle w%0d: got %0d want %0d", w, rc, e.rdy); else pass_n++;
            chk_n++; if (o_cpu_q !== e.q || o_cpu_q_select !== e.sel || nr !== 1)
                $display("FAIL rd_word w%0d: got %h/%b n=%0d want %h/%b n=1", w, o_cpu_q, o_cpu_q_select, nr, e.q, e.sel);
            else pass_n++;
        end
    endtask

    task automatic test_float();
        int rc, nr;
        exp_t e;
        logic [0:14] addrs [2];
        addrs[0] = 15'h2000; addrs[1] = 15'h3000;
        use4 = 1'b0;
        sb.push_back('{16'hFFFF, 1'b0, 5});
        sb.push_back('{16'hFF77, 1'b1, 5});
        for (int i = 0; i < 2; i++) begin
            run_txn(1'b0, addrs[i], 16'h0000, 0, 0, 0, -10, 20, rc, nr);
            e = sb.pop_front();
            model_q = e.q; model_sel = e.sel;
            chk_n++; if (o_cpu_q !== e.q || o_cpu_q_select !== e.sel || rc !== e.rdy)
                $display("FAIL float_read %0d: got %h/%b c%0d want %h/%b c%0d", i, o_cpu_q, o_cpu_q_select, rc, e.q, e.sel, e.rdy);
            else pass_n++;
        end
    endtask

    task automatic test_stall();
        int rc, nr;
        bit addr_ok;
        exp_t e;
        use4 = 1'b0;
        sb.push_back('{16'h1234, 1'b1, 8});
        run_txn(1'b0, 15'h5000, 16'h0000, 0, 2, 3, -10, 20, rc, nr);
        e = sb.pop_front();
        model_q = e.q; model_sel = e.sel;
        addr_ok = 1'b1;
        for (int i = 0; i < 5; i++) if (addr_log[i] !== 16'hA001) addr_ok = 1'b0;
        chk_n++; if (rc !== e.rdy) $display("FAIL stall_ready_cycle: got %0d want %0d", rc, e.rdy); else pass_n++;
        chk_n++; if (pulse_cyc.size() !== 2 || pulse_cyc[1] !== 6)
            $display("FAIL stall_even_acc: got n=%0d c%0d want n=2 c6", pulse_cyc.size(), pulse_cyc[1]);
        else pass_n++;
        chk_n++; if (addr_ok !== 1'b1) $display("FAIL stall_addr_stable: got %b want 1", addr_ok); else pass_n++;
        chk_n++; if (o_cpu_q !== e.q) $display("FAIL stall_word: got %h want %h", o_cpu_q, e.q); else pass_n++;
    endtask

    task automatic test_hold();
        int rc, nr;
        exp_t e;
        use4 = 1'b0;
        sb.push_back('{16'h1234, 1'b1, 5});
        run_txn(1'b0, 15'h5000, 16'h0000, 30, 0, 0, -10, 34, rc, nr);
        e = sb.pop_front();
        model_q = e.q; model_sel = e.sel;
        chk_n++; if (pulse_cyc.size() !== 2) $display("FAIL hold_pulse_count: got %0d want 2", pulse_cyc.size()); else pass_n++;
        chk_n++; if (nr !== 1 || rc !== e.rdy) $display("FAIL hold_ready: got n=%0d c%0d want n=1 c%0d", nr, rc, e.rdy); else pass_n++;
        chk_n++; if (b2b !== 1'b0) $display("FAIL hold_consecutive_strobe: got %b want 0", b2b); else pass_n++;
    endtask

    task automatic test_back_to_back();
        int rc, nr;
        exp_t e;
        use4 = 1'b0;
        sb.push_back('{16'hFF77, 1'b1, 5});
        run_txn(1'b0, 15'h3000, 16'h0000, 0, 0, 0, -10, 20, rc, nr);
        e = sb.pop_front();
        model_q = e.q; model_sel = e.sel;
        chk_n++; if (o_cpu_q !== e.q || o_cpu_q_select !== e.sel || rc !== e.rdy)
            $display("FAIL b2b_read: got %h/%b c%0d want %h/%b c%0d", o_cpu_q, o_cpu_q_select, rc, e.q, e.sel, e.rdy);
        else pass_n++;
    endtask

    task automatic test_reset_mid();
        int rc, nr;
        exp_t e;
        use4 = 1'b1;
        run_txn(1'b0, 15'h5000, 16'h0000, 0, 0, 0, 8, 20, rc, nr);
        model_q = 16'h0000; model_sel = 1'b0;
        chk_n++; if (nr !== 0) $display("FAIL rstmid_no_ready: got %0d want 0", nr); else pass_n++;
        chk_n++; if (snap !== 44'h0) $display("FAIL rstmid_outputs: got %h want 0", snap); else pass_n++;
        chk_n++; if (o_cpu_q !== model_q || o_cpu_q_select !== model_sel)
            $display("FAIL rstmid_q_cleared: got %h/%b want %h/%b", o_cpu_q, o_cpu_q_select, model_q, model_sel);
        else pass_n++;
        sb.push_back('{16'h1234, 1'b1, 11});
        run_txn(1'b0, 15'h5000, 16'h0000, 0, 0, 0, -10, 20, rc, nr);
        e = sb.pop_front();
        model_q = e.q; model_sel = e.sel;
        chk_n++; if (o_cpu_q !== e.q || o_cpu_q_select !== e.sel || rc !== e.rdy || pulse_cyc.size() !== 2)
            $display("FAIL rstmid_clean_txn: got %h/%b c%0d n=%0d want %h/%b c%0d n=2", o_cpu_q, o_cpu_q_select, rc, pulse_cyc.size(), e.q, e.sel, e.rdy);
        else pass_n++;
    endtask

    initial begin
        test_reset();
        test_write_w1();
        test_read_back();
        test_float();
        test_stall();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_n, chk_n);
        $finish;
    end

endmodule

// File: doc/peb_datamux.md
Name: peb_datamux

Overview:
16-to-8-bit data multiplexer between the TMS9900 16-bit CPU memory bus and the 8-bit PEB expansion bus that the PEB cards (32K RAM and others) hang off.
- Each CPU word access becomes two sequential byte accesses, odd byte (A15=1) first, then even byte (A15=0).
- Wait states are inserted, and the read bytes are assembled into a 16-bit word.
- cpu_ready is pulsed for one cycle when the word is complete.

Parameters:
WAIT_STATES, 4, wait cycles per byte access after the strobe cycle; legal range 1..15.
FLOAT_BYTE, 8'hFF, byte returned for a read byte whose peb_q_select is low.

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
cpu_a  input  15 [0:14]  CPU word address (A0..A14)
cpu_d  input  16 [0:15]  CPU write data; [0:7] even byte, [8:15] odd byte
cpu_q  output  16 [0:15]  assembled read word, same byte order as cpu_d
cpu_q_select  output  1  at least one byte of the last read was claimed by a card
cpu_memen  input  1  CPU memory cycle request, level, held until cpu_ready seen
cpu_we  input  1  1 = write cycle
cpu_ready  output  1  one-cycle completion pulse
peb_a  output  16 [0:15]  PEB byte address
peb_d  output  8 [0:7]  PEB write data
peb_q  input  8 [0:7]  PEB read data; registered by the card, valid from the cycle after the strobe
peb_q_select  input  1  a card claims peb_a; combinational from peb_a
peb_memen  output  1  one-cycle byte strobe
peb_we  output  1  byte write enable, qualified by peb_memen
peb_ready  input  1  card ready; 0 extends the wait phase

Behaviour:
- Reset:
  - state IDLE; cpu_q=0, cpu_q_select=0, cpu_ready=0.
  - peb_a=0, peb_d=0, peb_memen=0, peb_we=0.
  - Reset wins over every other event. A reset asserted mid-transaction returns to IDLE at that edge: peb_memen=0 from the next cycle, no cpu_ready pulse, cpu_q unchanged from the pre-reset value except that reset clears it.
- Registered outputs: all outputs are registered.
- Latching at start: on the edge where IDLE sees cpu_memen=1, latch cpu_a, cpu_d and cpu_we, and enter ODD_ACC.
- ODD_ACC (1 cycle):
  - peb_a={a,1'b1}; peb_memen=1; peb_we=we; peb_d=d[8:15].
  - Load the wait counter with WAIT_STATES. Go to ODD_WAIT.
- ODD_WAIT:
  - peb_memen=0; peb_a held stable.
  - Counter decrements each cycle to 0 and then stays.
  - Leave when counter==1 or 0 and peb_ready=1, i.e. at least WAIT_STATES cycles are spent here.
  - On leaving a read, latch lo byte = peb_q_select ? peb_q : FLOAT_BYTE, and lo_sel = peb_q_select.
  - Next state: EVEN_ACC.
- EVEN_ACC / EVEN_WAIT:
  - Same as the odd pair, with peb_a={a,1'b0} and peb_d=d[0:7].
  - Latch hi byte and hi_sel. Next state: DONE.
- DONE (1 cycle):
  - cpu_ready=1.
  - On reads: cpu_q={hi,lo}; cpu_q_select=hi_sel|lo_sel.
  - On writes: cpu_q and cpu_q_select hold their previous values.
  - Next state: HOLD.
- HOLD:
  - Stay while cpu_memen=1; go to IDLE when cpu_memen=0.
  - A held cpu_memen never starts a second transaction; one transaction per memen assertion.
- Latency with peb_ready=1:
  - Edge 0 = IDLE samples memen.
  - ODD_ACC in cycle 1; EVEN_ACC in cycle WAIT_STATES+2; cpu_ready high in cycle 2*WAIT_STATES+3 (cycle 11 for the default).
  - Each cycle peb_ready is low at the exit point adds one cycle.
- No timeout: peb_ready low stalls indefinitely.
- cpu_a/cpu_d changes after latching have no effect on the transaction in flight.
- Exactly one peb_memen pulse per byte; peb_memen is never high in two consecutive cycles.

Test Plan:
- Write, WAIT_STATES=1, cpu_a=word >A000, cpu_d=16'h1234, we=1 -> peb_memen pulse cycle 1 with peb_a=16'hA001, peb_d=8'h34, peb_we=1; cycle 3 with peb_a=16'hA000, peb_d=8'h12; cpu_ready in cycle 5 only.
- Read back >A000 from a model with registered q -> cpu_q=16'h1234, cpu_q_select=1, cpu_ready in cycle 2*W+3; repeat with W=4 -> cycle 11.
- Read at >4000 with peb_q_select=0, peb_q=8'h5A -> cpu_q=16'hFFFF, cpu_q_select=0; with only the odd byte selected (8'h77) -> cpu_q=16'hFF77, cpu_q_select=1.
- peb_ready held low 3 cycles during ODD_WAIT (W=1) -> EVEN_ACC delayed by exactly 3 cycles, cpu_ready at cycle 8; peb_a stays 16'hA001 throughout the stall.
- cpu_memen held high for 30 cycles -> exactly two peb_memen pulses and one cpu_ready; a new transaction starts only after memen drops and rises again.
- reset asserted during EVEN_WAIT -> no cpu_ready; all outputs 0 the following cycle; the next memen performs a clean full transaction.
